// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus the tx/rx word handshake of spi_slave, with DUT/driver modports.
`default_nettype none
`timescale 1ns/1ps

interface spi_slave_if #(
    parameter int DATA_W = 8
);
    logic              sclk;
    logic              ss_n;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;
    logic              frame_err;

    modport slave (
        input  sclk, ss_n, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, frame_err
    );

    modport master (
        output sclk, ss_n, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, frame_err
    );
endinterface

`default_nettype wire

// File: rtl/spi_slave.sv
// +--------------------------------------------------------------------------+
// | spi_slave: SPI mode-0 MSB-first slave, oversampled in the clk domain.    |
// | Option macro SPI_SLAVE_LOOPBACK_EN: underrun echoes the last rx word.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module spi_slave #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    spi_slave_if.slave  bus
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic sclk_d, ss_d;
    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_fall;

    logic [DATA_W-1:0] shift_reg, hold_reg, rx_data_q, load_word, underrun_word;
    logic              hold_full, rx_bit, miso_q, rx_valid_q, busy_q, frame_err_q;
    logic [CNT_W-1:0]  bit_cnt;
    logic              tx_load, consume;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ss_d      <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_fall   = ~ss_s & ss_d;

`ifdef SPI_SLAVE_LOOPBACK_EN
    assign underrun_word = rx_data_q;
`else
    assign underrun_word = '1;
`endif

    assign load_word = hold_full ? hold_reg : underrun_word;
    assign tx_load   = bus.tx_valid & ~hold_full;
    // The fall that ends a word (count already wrapped) starts the next one.
    assign consume   = (state == LOAD) ||
                       ((state == SHIFT) && !ss_s && sclk_fall && (bit_cnt == '0));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = LOAD;
            LOAD:    state_nxt = ss_s ? IDLE : SHIFT;
            SHIFT:   if (ss_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_reg   <= '0;
            hold_reg    <= '0;
            hold_full   <= 1'b0;
            rx_data_q   <= '0;
            rx_bit      <= 1'b0;
            miso_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            bit_cnt     <= '0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;

            if (tx_load) begin
                hold_reg  <= bus.tx_data;
                hold_full <= 1'b1;
            end else if (consume) begin
                hold_full <= 1'b0;
            end

            case (state)
                LOAD: begin
                    shift_reg <= load_word;
                    miso_q    <= load_word[DATA_W-1];
                    bit_cnt   <= '0;
                end
                SHIFT: begin
                    if (ss_s) begin
                        miso_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        bit_cnt <= '0;
                        if (bit_cnt != '0) frame_err_q <= 1'b1;
                    end else if (sclk_rise) begin
                        // Sampled bit is held aside so the LSB still to be sent survives.
                        rx_bit <= mosi_s;
                        busy_q <= 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            rx_data_q  <= {shift_reg[DATA_W-2:0], mosi_s};
                            rx_valid_q <= 1'b1;
                            busy_q     <= 1'b0;
                            bit_cnt    <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt == '0) begin
                            shift_reg <= load_word;
                            miso_q    <= load_word[DATA_W-1];
                        end else begin
                            shift_reg <= {shift_reg[DATA_W-2:0], rx_bit};
                            miso_q    <= shift_reg[DATA_W-2];
                        end
                    end
                end
                default: begin
                    miso_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.miso      = miso_q;
    assign bus.miso_oe   = ~ss_s;
    assign bus.tx_ready  = ~hold_full;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.busy      = busy_q;
    assign bus.frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI master stimulus with a receive-word scoreboard for spi_slave.
`default_nettype none
`timescale 1ns/1ps

module tb_spi_slave;
    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    spi_slave_if #(.DATA_W(DATA_W)) bus ();

    spi_slave #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int rx_cnt = 0;
    int ferr_cnt = 0;
    logic [7:0] rx_q[$];
    logic [7:0] last_rx = 8'h00;
    logic [7:0] mon_exp;
    logic [7:0] e1, e2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) ferr_cnt++;
        if (bus.rx_valid === 1'b1) begin
            rx_cnt++;
            if (rx_q.size() == 0) begin
                check("rx_unexpected", rx_q.size(), 1);
            end else begin
                mon_exp = rx_q.pop_front();
                check("rx_data", bus.rx_data, mon_exp);
                check("rx_latency", cyc - last_rise_cyc, SYNC_STAGES + 1);
                check("busy_at_valid", bus.busy, 0);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic stage(input logic [7:0] d);
        int t = 0;
        while (bus.tx_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("stage_ready", bus.tx_ready, 1);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    // Mode-0 master: data set while SCLK low, miso sampled at the rising edge.
    task automatic xfer(input logic [7:0] w, input logic [7:0] exp_miso,
                        input bit chk_miso, input int nbits);
        logic [7:0] got = 8'h00;
        if (nbits == 8) begin
            rx_q.push_back(w);
            last_rx = w;
        end
        for (int i = 7; i >= 8 - nbits; i--) begin
            bus.mosi = w[i];
            wait_clk(6);
            got[i] = bus.miso;
            if (i == 7) check("miso_oe_active", bus.miso_oe, 1);
            bus.sclk = 1'b1;
            last_rise_cyc = cyc;
            wait_clk(6);
            if (i == 4) check("busy_mid", bus.busy, 1);
            bus.sclk = 1'b0;
        end
        if (chk_miso) check("miso_word", got, exp_miso);
    endtask

    task automatic frame_begin();
        bus.ss_n = 1'b0;
        wait_clk(10);
    endtask

    task automatic frame_end();
        wait_clk(6);
        bus.ss_n = 1'b1;
        wait_clk(10);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.sclk = 1'b0; bus.ss_n = 1'b1; bus.mosi = 1'b0;
        bus.tx_data = 8'h00; bus.tx_valid = 1'b0;
        wait_clk(3);
        check("rst_miso", bus.miso, 0);
        check("rst_miso_oe", bus.miso_oe, 0);
        check("rst_tx_ready", bus.tx_ready, 1);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_frame_err", bus.frame_err, 0);
        rstn = 1'b1;
        wait_clk(3);

        // 1: reset mid-activity
        stage(8'h77);
        check("t1_tx_ready_full", bus.tx_ready, 0);
        frame_begin();
        bus.mosi = 1'b1;
        bus.sclk = 1'b1;
        wait_clk(4);
        check("t1_busy_pre", bus.busy, 1);
        rstn = 1'b0;
        wait_clk(5);
        check("t1_tx_ready", bus.tx_ready, 1);
        check("t1_miso", bus.miso, 0);
        check("t1_miso_oe", bus.miso_oe, 0);
        check("t1_busy", bus.busy, 0);
        bus.sclk = 1'b0;
        bus.ss_n = 1'b1;
        wait_clk(2);
        rstn = 1'b1;
        wait_clk(5);
        check("t1_post_tx_ready", bus.tx_ready, 1);
        check("t1_post_miso_oe", bus.miso_oe, 0);

        // 2: single word
        stage(8'hA5);
        frame_begin();
        xfer(8'h3C, 8'hA5, 1, 8);
        frame_end();
        check("t2_rx_cnt", rx_cnt, 1);

        // 3: back-to-back words with staging during the frame
        stage(8'h12);
        frame_begin();
        stage(8'h34);
        check("t3_tx_ready_full", bus.tx_ready, 0);
        xfer(8'hF0, 8'h12, 1, 8);
        xfer(8'h0F, 8'h34, 1, 8);
        frame_end();
        check("t3_rx_cnt", rx_cnt, 3);

        // 4: aborted frame, then a clean one
        frame_begin();
        xfer(8'hAA, 8'h00, 0, 5);
        frame_end();
        check("t4_ferr_cnt", ferr_cnt, 1);
        check("t4_rx_cnt", rx_cnt, 3);
        check("t4_rx_hold", bus.rx_data, 8'h0F);
        stage(8'h5A);
        frame_begin();
        xfer(8'hC3, 8'h5A, 1, 8);
        frame_end();
        check("t4_next_rx_cnt", rx_cnt, 4);

        // 5: underrun
`ifdef SPI_SLAVE_LOOPBACK_EN
        e1 = last_rx;
        e2 = 8'h55;
`else
        e1 = 8'hFF;
        e2 = 8'hFF;
`endif
        frame_begin();
        xfer(8'h55, e1, 1, 8);
        xfer(8'h00, e2, 1, 8);
        frame_end();
        check("t5_rx_cnt", rx_cnt, 6);

        // 6: SCLK activity while deselected
        for (int i = 0; i < 8; i++) begin
            bus.mosi = i[0];
            bus.sclk = 1'b1;
            wait_clk(6);
            bus.sclk = 1'b0;
            wait_clk(6);
        end
        check("t6_miso_oe", bus.miso_oe, 0);
        check("t6_rx_cnt", rx_cnt, 6);
        stage(8'h81);
        frame_begin();
        xfer(8'h7E, 8'h81, 1, 8);
        frame_end();
        check("t6_next_rx_cnt", rx_cnt, 7);
        check("t6_ferr_cnt", ferr_cnt, 1);
        check("scoreboard_empty", rx_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
